llc_mem_bridge: RTL
===================

Name: llc_mem_bridge

Overview:
- Memory-side responder for the LLC-to-memory channel.
- Accepts one line-granular LLC memory request (read or write-back) and splits it into WORDS_PER_LINE word-wide beats on a simple word memory port.
- For reads, reassembles the returned words into one line response back to the LLC.
- Sits between the LLC and the SoC memory/NoC adapter; at most one LLC request is outstanding.

Parameters:
- BITS_PER_WORD, 32, width of one memory beat and one line word.
- WORDS_PER_LINE, 4, beats per line (power of 2, ≥2).
- LINE_ADDR_BITS, 28, width of the LLC line address.
- ADDR_BITS, LINE_ADDR_BITS+clog2(WORDS_PER_LINE)+clog2(BITS_PER_WORD/8), byte address width on the memory side.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- llc_mem_req_valid  in  1  LLC request valid.
- llc_mem_req_ready  out  1  bridge can accept a request.
- llc_mem_req_hwrite  in  1  1=write-back line, 0=read line.
- llc_mem_req_hsize  in  3  forwarded unchanged on every beat.
- llc_mem_req_hprot  in  2  forwarded unchanged on every beat.
- llc_mem_req_addr  in  LINE_ADDR_BITS  line address.
- llc_mem_req_line  in  BITS_PER_WORD*WORDS_PER_LINE  write data.
- llc_mem_rsp_valid  out  1  read line ready.
- llc_mem_rsp_ready  in  1  LLC accepts line.
- llc_mem_rsp_line  out  BITS_PER_WORD*WORDS_PER_LINE  assembled read line.
- mem_req_valid  out  1  beat request valid.
- mem_req_ready  in  1  memory accepts beat.
- mem_req_write  out  1  beat is a write.
- mem_req_addr  out  ADDR_BITS  byte address of the beat.
- mem_req_hsize  out  3  copy of captured hsize.
- mem_req_hprot  out  2  copy of captured hprot.
- mem_req_wdata  out  BITS_PER_WORD  write word.
- mem_rsp_valid  in  1  read word valid.
- mem_rsp_ready  out  1  bridge accepts read word.
- mem_rsp_rdata  in  BITS_PER_WORD  read word.

Behaviour:
- Handshakes: a transfer occurs on a rising clk with valid&&ready. A valid source holds valid and payload stable until the transfer.
- FSM states: IDLE, READ, WRITE, RSP. Reset (rst low, asynchronous) → IDLE, both counters 0, captured-request and line registers 0.
- Reset outputs: mem_req_valid=0, llc_mem_rsp_valid=0, mem_rsp_ready=0, llc_mem_req_ready=1 (IDLE). All data outputs are 0.
- llc_mem_req_ready = (state==IDLE), combinational from state only.
- IDLE: on an LLC request handshake, capture hwrite/hsize/hprot/addr/line and go to WRITE if hwrite=1, else READ. Both counters clear.
- Beat addressing: beat i has mem_req_addr = {line_addr, i[clog2(W)-1:0], zero byte offset}. Beat i carries word i = line[i*BITS_PER_WORD +: BITS_PER_WORD]. Beats are issued in ascending i, with no wrap or critical-word-first.
- WRITE:
  - mem_req_valid=1, mem_req_write=1, wdata = word req_cnt.
  - req_cnt increments on each beat handshake.
  - On the handshake of beat W-1, go to IDLE; mem_req_valid is 0 the next cycle.
  - No LLC response is generated for writes.
- READ:
  - Issue side: mem_req_valid=1 while req_cnt<W; mem_req_write=0; req_cnt increments per handshake.
  - Collect side: mem_rsp_ready=1 throughout READ; each accepted word is written to line slot rsp_cnt, and rsp_cnt increments.
  - Issue and collect run concurrently; responses are in order and may overlap requests.
  - A response arriving in the same cycle as a request handshake is legal.
  - On acceptance of word W-1, go to RSP.
- RSP:
  - llc_mem_rsp_valid=1 and llc_mem_rsp_line = assembled line, held until llc_mem_rsp_ready.
  - On that handshake go to IDLE. The next LLC request can be accepted one cycle later, not in the same cycle.
- mem_rsp_ready=0 outside READ; words offered outside READ are not accepted.
- Latency:
  - LLC request handshake at cycle 0 → first mem_req_valid at cycle 1.
  - Last read word accepted at cycle n → llc_mem_rsp_valid at cycle n+1.
  - With zero-wait memory (mem_rsp the cycle after each request), a read completes in W+2 cycles.
- Counters are clog2(W)+1 bits wide, so req_cnt can reach W without wrapping.
- Reset mid-operation: the transaction is discarded, with no partial response and no further beats.

Decomposition:
- Shared package/consts supply BITS_PER_WORD, WORDS_PER_LINE, LINE_ADDR_BITS, ADDR_BITS, and the hsize_t, hprot_t, word_t, line_t, line_addr_t and addr_t typedefs.
- The bridge state enum is local to this module.
- No sub-module is needed: the counters and line register stay inline.

Test Plan (W=4, BITS_PER_WORD=32):
- Read, zero-wait memory:
  - Stimulus: line_addr 0x0000123, rdata 0xA0,0xA1,0xA2,0xA3.
  - Required: addrs 0x1230/0x1234/0x1238/0x123C with write=0, then rsp_line 0x000000A3_000000A2_000000A1_000000A0, valid exactly 6 cycles after the request handshake.
- Write:
  - Stimulus: line 0x44444444_33333333_22222222_11111111 at line_addr 0x1.
  - Required: 4 beats, addrs 0x10–0x1C, wdata 0x11111111..0x44444444 in order, then llc_mem_req_ready=1, and llc_mem_rsp_valid never rises.
- Backpressure:
  - Stimulus: mem_req_ready low for 3 cycles on beat 2, then llc_mem_rsp_ready low for 5 cycles.
  - Required: addr/wdata and rsp_line are held stable, and no beat is duplicated or skipped.
- Overlapped responses:
  - Stimulus: each response arrives in the same cycle as the next request handshake.
  - Required: the correct line is assembled and rsp_cnt==4 exactly at the RSP transition.
- Stray response:
  - Stimulus: mem_rsp_valid=1 in IDLE and in WRITE.
  - Required: mem_rsp_ready=0 and the state is unchanged.
- Reset mid-read:
  - Stimulus: rst low after 2 words are accepted.
  - Required: outputs return to reset values asynchronously, and a following read of 0x0000124 returns only its own data.

Source files
------------

// File: rtl/llc_mem_bridge_pkg.sv
// Shared widths and types for the LLC-to-memory line/word bridge.
package llc_mem_bridge_pkg;

  localparam int unsigned BITS_PER_WORD  = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_ADDR_BITS = 28;
  localparam int unsigned WORD_IDX_BITS  = $clog2(WORDS_PER_LINE);
  localparam int unsigned BYTE_OFF_BITS  = $clog2(BITS_PER_WORD / 8);
  localparam int unsigned ADDR_BITS      = LINE_ADDR_BITS + WORD_IDX_BITS + BYTE_OFF_BITS;
  localparam int unsigned LINE_BITS      = BITS_PER_WORD * WORDS_PER_LINE;
  // One extra bit so a beat counter can reach WORDS_PER_LINE without wrapping.
  localparam int unsigned CNT_BITS       = WORD_IDX_BITS + 1;

  typedef logic [2:0]                hsize_t;
  typedef logic [1:0]                hprot_t;
  typedef logic [BITS_PER_WORD-1:0]  word_t;
  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [ADDR_BITS-1:0]      addr_t;

  function automatic addr_t beat_addr(line_addr_t line_addr, logic [WORD_IDX_BITS-1:0] idx);
    return {line_addr, idx, {BYTE_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_mem_bridge.sv
// Splits one LLC line request into word beats on the memory port and, for reads,
// reassembles the returned words into a single line response.
module llc_mem_bridge
  import llc_mem_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       llc_mem_req_valid,
  output logic       llc_mem_req_ready,
  input  logic       llc_mem_req_hwrite,
  input  hsize_t     llc_mem_req_hsize,
  input  hprot_t     llc_mem_req_hprot,
  input  line_addr_t llc_mem_req_addr,
  input  line_t      llc_mem_req_line,
  output logic       llc_mem_rsp_valid,
  input  logic       llc_mem_rsp_ready,
  output line_t      llc_mem_rsp_line,
  output logic       mem_req_valid,
  input  logic       mem_req_ready,
  output logic       mem_req_write,
  output addr_t      mem_req_addr,
  output hsize_t     mem_req_hsize,
  output hprot_t     mem_req_hprot,
  output word_t      mem_req_wdata,
  input  logic       mem_rsp_valid,
  output logic       mem_rsp_ready,
  input  word_t      mem_rsp_rdata
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StRsp} state_e;

  localparam logic [CNT_BITS-1:0] LastBeat = CNT_BITS'(WORDS_PER_LINE - 1);
  localparam logic [CNT_BITS-1:0] NumBeats = CNT_BITS'(WORDS_PER_LINE);

  state_e                    state_q, state_d;
  logic [CNT_BITS-1:0]       req_cnt_q, req_cnt_d;
  logic [CNT_BITS-1:0]       rsp_cnt_q, rsp_cnt_d;
  hsize_t                    hsize_q, hsize_d;
  hprot_t                    hprot_q, hprot_d;
  line_addr_t                addr_q, addr_d;
  line_t                     line_q, line_d;
  logic [WORD_IDX_BITS-1:0]  req_idx, rsp_idx;
  logic                      read_issue;

  assign req_idx    = req_cnt_q[WORD_IDX_BITS-1:0];
  assign rsp_idx    = rsp_cnt_q[WORD_IDX_BITS-1:0];
  assign read_issue = (req_cnt_q < NumBeats);

  always_comb begin
    llc_mem_req_ready = (state_q == StIdle);
    mem_req_valid     = (state_q == StWrite) || ((state_q == StRead) && read_issue);
    mem_req_write     = (state_q == StWrite);
    mem_req_addr      = beat_addr(addr_q, req_idx);
    mem_req_hsize     = hsize_q;
    mem_req_hprot     = hprot_q;
    mem_req_wdata     = line_q[req_idx*BITS_PER_WORD +: BITS_PER_WORD];
    mem_rsp_ready     = (state_q == StRead);
    llc_mem_rsp_valid = (state_q == StRsp);
    llc_mem_rsp_line  = (state_q == StRsp) ? line_q : '0;
  end

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    hsize_d   = hsize_q;
    hprot_d   = hprot_q;
    addr_d    = addr_q;
    line_d    = line_q;
    unique case (state_q)
      StIdle: begin
        if (llc_mem_req_valid) begin
          hsize_d   = llc_mem_req_hsize;
          hprot_d   = llc_mem_req_hprot;
          addr_d    = llc_mem_req_addr;
          line_d    = llc_mem_req_line;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          state_d   = llc_mem_req_hwrite ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (mem_req_ready) begin
          req_cnt_d = req_cnt_q + 1'b1;
          if (req_cnt_q == LastBeat) state_d = StIdle;
        end
      end
      StRead: begin
        // Issue and collect proceed independently; responses return in order.
        if (read_issue && mem_req_ready) req_cnt_d = req_cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          line_d[rsp_idx*BITS_PER_WORD +: BITS_PER_WORD] = mem_rsp_rdata;
          rsp_cnt_d = rsp_cnt_q + 1'b1;
          if (rsp_cnt_q == LastBeat) state_d = StRsp;
        end
      end
      StRsp: begin
        if (llc_mem_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      hsize_q   <= '0;
      hprot_q   <= '0;
      addr_q    <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      hsize_q   <= hsize_d;
      hprot_q   <= hprot_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
    end
  end

endmodule
